fetch_stage: RTL and testbench

Instruction-fetch stage with PC register, IF/ID pipeline register and a one-entry skid buffer. Sits directly upstream of the load-use stall generator and feeds decode. It honours the stall-generator hold request with an enable rather than a gated clock, and redirects on taken branches with a flush. It drives a simple request/acknowledge instruction-memory port that tolerates wait states.

---
 rtl/riscv_pkg.sv | 24 ++
 rtl/if_id_reg.sv | 27 ++
 rtl/fetch_stage.sv | 107 ++++++++++
 tb/tb_fetch_stage.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32 pipeline constants and the fetch-stage types.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package riscv_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC = 32'h0040_0000;
    localparam logic [31:0]     NOP      = 32'h0000_0013;

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc4;
        logic [31:0]     instr;
    } if_id_t;

    localparam if_id_t IF_ID_RESET = '{valid: 1'b0, pc: '0, pc4: '0, instr: NOP};

endpackage

// File: rtl/if_id_reg.sv
// Valid/pc/pc4/instr pipeline register with load, hold and bubble controls.
// Latency: 1 cycle from d_i to q_o when load_i is set.
// Backpressure: holds its contents whenever neither load_i nor bubble_i is set.
module if_id_reg
    import riscv_pkg::*;
(
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   load_i,
    input  logic   bubble_i,
    input  if_id_t d_i,
    output if_id_t q_o
);

    // A bubble keeps the stale pc fields; only valid and instr are meaningful.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q_o <= IF_ID_RESET;
        end else if (bubble_i) begin
            q_o.valid <= 1'b0;
            q_o.instr <= NOP;
        end else if (load_i) begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, req/ack imem port, IF/ID register and one-entry skid.
// Latency: word acked in cycle N appears on if_id_* in N+1.
// Backpressure: stall_i holds IF/ID and PC; a word acked under stall parks in the skid.
module fetch_stage
    import riscv_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic [XLEN-1:0] branch_target_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_ack_i,
    input  logic [31:0]     imem_rdata_i,
    output logic            if_id_valid_o,
    output logic [XLEN-1:0] if_id_pc_o,
    output logic [XLEN-1:0] if_id_pc4_o,
    output logic [31:0]     if_id_instr_o
);

    fetch_state_t    state, state_n;
    logic [XLEN-1:0] pc, pc_n, pc_plus4;

    logic   ifid_load, ifid_bubble;
    logic   skid_load, skid_bubble;
    if_id_t ifid_d, ifid_q, skid_q, fetched;

    assign pc_plus4 = pc + 32'd4;
    assign fetched  = '{valid: 1'b1, pc: pc, pc4: pc_plus4, instr: imem_rdata_i};

    always_comb begin
        state_n     = state;
        pc_n        = pc;
        ifid_load   = 1'b0;
        ifid_bubble = 1'b0;
        ifid_d      = fetched;
        skid_load   = 1'b0;
        skid_bubble = 1'b0;
        if (flush_i) begin
            pc_n        = branch_target_i & ~32'h3;
            state_n     = FETCH;
            ifid_bubble = 1'b1;
            skid_bubble = 1'b1;
        end else if (stall_i) begin
            // Accept the in-flight word so it is neither lost nor refetched.
            if (state == FETCH && imem_ack_i) begin
                skid_load = 1'b1;
                pc_n      = pc_plus4;
                state_n   = HOLD;
            end
        end else begin
            case (state)
                FETCH: begin
                    if (imem_ack_i) begin
                        ifid_load = 1'b1;
                        pc_n      = pc_plus4;
                    end else begin
                        ifid_bubble = 1'b1;
                    end
                end
                HOLD: begin
                    ifid_load = 1'b1;
                    ifid_d    = skid_q;
                    state_n   = FETCH;
                end
                default: state_n = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= FETCH;
            pc    <= RESET_PC;
        end else begin
            state <= state_n;
            pc    <= pc_n;
        end
    end

    if_id_reg u_if_id (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .load_i   (ifid_load),
        .bubble_i (ifid_bubble),
        .d_i      (ifid_d),
        .q_o      (ifid_q)
    );

    if_id_reg u_skid (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .load_i   (skid_load),
        .bubble_i (skid_bubble),
        .d_i      (fetched),
        .q_o      (skid_q)
    );

    assign imem_req_o    = (state == FETCH) & ~rst_i;
    assign imem_addr_o   = pc;
    assign if_id_valid_o = ifid_q.valid;
    assign if_id_pc_o    = ifid_q.pc;
    assign if_id_pc4_o   = ifid_q.pc4;
    assign if_id_instr_o = ifid_q.instr;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; memory returns ~addr for every fetched word.
module tb_fetch_stage;
    import riscv_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i, stall_i, flush_i, imem_ack_i;
    logic [31:0] branch_target_i;
    logic        imem_req_o, if_id_valid_o;
    logic [31:0] imem_addr_o, imem_rdata_i, if_id_pc_o, if_id_pc4_o, if_id_instr_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    assign imem_rdata_i = ~imem_addr_o;

    fetch_stage dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .stall_i         (stall_i),
        .flush_i         (flush_i),
        .branch_target_i (branch_target_i),
        .imem_req_o      (imem_req_o),
        .imem_addr_o     (imem_addr_o),
        .imem_ack_i      (imem_ack_i),
        .imem_rdata_i    (imem_rdata_i),
        .if_id_valid_o   (if_id_valid_o),
        .if_id_pc_o      (if_id_pc_o),
        .if_id_pc4_o     (if_id_pc4_o),
        .if_id_instr_o   (if_id_instr_o)
    );

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; stall_i = 1'b0; flush_i = 1'b0; imem_ack_i = 1'b1; branch_target_i = '0;
        step(); step();
        checks++; if (if_id_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %h exp 0", if_id_valid_o); end
        checks++; if (if_id_instr_o !== 32'h13) begin errors++; $display("FAIL reset_instr got %h exp 00000013", if_id_instr_o); end
        checks++; if (if_id_pc_o !== 32'h0 || if_id_pc4_o !== 32'h0) begin errors++; $display("FAIL reset_pc got %h/%h exp 0/0", if_id_pc_o, if_id_pc4_o); end
        checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", imem_req_o); end
        checks++; if (imem_addr_o !== 32'h0040_0000) begin errors++; $display("FAIL reset_addr got %h exp 00400000", imem_addr_o); end
        rst_i = 1'b0;
        #1;
        checks++; if (imem_req_o !== 1'b1) begin errors++; $display("FAIL req_after_reset got %b exp 1", imem_req_o); end
    endtask

    task automatic test_stream();
        imem_ack_i = 1'b1;
        step();
        checks++; if (if_id_valid_o !== 1'b1 || if_id_pc_o !== 32'h0040_0000) begin errors++; $display("FAIL stream0 got v=%b pc=%h exp v=1 pc=00400000", if_id_valid_o, if_id_pc_o); end
        checks++; if (if_id_instr_o !== 32'hFFBF_FFFF || if_id_pc4_o !== 32'h0040_0004) begin errors++; $display("FAIL stream0_data got %h/%h exp ffbfffff/00400004", if_id_instr_o, if_id_pc4_o); end
        step();
        checks++; if (if_id_valid_o !== 1'b1 || if_id_pc_o !== 32'h0040_0004 || if_id_instr_o !== 32'hFFBF_FFFB) begin errors++; $display("FAIL stream1 got v=%b pc=%h i=%h exp 1/00400004/ffbffffb", if_id_valid_o, if_id_pc_o, if_id_instr_o); end
    endtask

    task automatic test_wait();
        imem_ack_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++; if (if_id_valid_o !== 1'b0 || if_id_instr_o !== 32'h13) begin errors++; $display("FAIL wait_bubble%0d got v=%b i=%h exp 0/00000013", i, if_id_valid_o, if_id_instr_o); end
            checks++; if (imem_addr_o !== 32'h0040_0008 || imem_req_o !== 1'b1) begin errors++; $display("FAIL wait_addr%0d got %h req=%b exp 00400008 req=1", i, imem_addr_o, imem_req_o); end
        end
        imem_ack_i = 1'b1;
        step();
        checks++; if (if_id_valid_o !== 1'b1 || if_id_pc_o !== 32'h0040_0008 || if_id_instr_o !== 32'hFFBF_FFF7) begin errors++; $display("FAIL wait_done got v=%b pc=%h i=%h exp 1/00400008/ffbffff7", if_id_valid_o, if_id_pc_o, if_id_instr_o); end
    endtask

    task automatic test_stall();
        stall_i = 1'b1; imem_ack_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (if_id_valid_o !== 1'b1 || if_id_pc_o !== 32'h0040_0008) begin errors++; $display("FAIL stall_hold%0d got v=%b pc=%h exp 1/00400008", i, if_id_valid_o, if_id_pc_o); end
            checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL stall_req%0d got %b exp 0", i, imem_req_o); end
        end
        stall_i = 1'b0; imem_ack_i = 1'b0;
        step();
        checks++; if (if_id_valid_o !== 1'b1 || if_id_pc_o !== 32'h0040_000C || if_id_instr_o !== 32'hFFBF_FFF3) begin errors++; $display("FAIL stall_release got v=%b pc=%h i=%h exp 1/0040000c/ffbffff3", if_id_valid_o, if_id_pc_o, if_id_instr_o); end
        checks++; if (imem_addr_o !== 32'h0040_0010 || imem_req_o !== 1'b1) begin errors++; $display("FAIL stall_next_addr got %h req=%b exp 00400010 req=1", imem_addr_o, imem_req_o); end
        imem_ack_i = 1'b1;
        step();
        checks++; if (if_id_pc_o !== 32'h0040_0010 || if_id_pc4_o !== 32'h0040_0014) begin errors++; $display("FAIL stall_nodup got %h/%h exp 00400010/00400014", if_id_pc_o, if_id_pc4_o); end
    endtask

    task automatic test_flush_hold();
        stall_i = 1'b1; imem_ack_i = 1'b1;
        step();
        flush_i = 1'b1; branch_target_i = 32'h0040_0103;
        step();
        checks++; if (imem_addr_o !== 32'h0040_0100 || imem_req_o !== 1'b1) begin errors++; $display("FAIL flush_hold_addr got %h req=%b exp 00400100 req=1", imem_addr_o, imem_req_o); end
        checks++; if (if_id_valid_o !== 1'b0 || if_id_instr_o !== 32'h13) begin errors++; $display("FAIL flush_hold_bubble got v=%b i=%h exp 0/00000013", if_id_valid_o, if_id_instr_o); end
        flush_i = 1'b0; stall_i = 1'b0;
        step();
        checks++; if (if_id_valid_o !== 1'b1 || if_id_pc_o !== 32'h0040_0100 || if_id_instr_o !== 32'hFFBF_FEFF) begin errors++; $display("FAIL flush_hold_target got v=%b pc=%h i=%h exp 1/00400100/ffbffeff", if_id_valid_o, if_id_pc_o, if_id_instr_o); end
    endtask

    task automatic test_flush_stall();
        flush_i = 1'b1; stall_i = 1'b1; imem_ack_i = 1'b1; branch_target_i = 32'h0040_0200;
        step();
        checks++; if (imem_addr_o !== 32'h0040_0200 || imem_req_o !== 1'b1) begin errors++; $display("FAIL flush_stall_addr got %h req=%b exp 00400200 req=1", imem_addr_o, imem_req_o); end
        checks++; if (if_id_valid_o !== 1'b0) begin errors++; $display("FAIL flush_stall_valid got %b exp 0", if_id_valid_o); end
        flush_i = 1'b0; stall_i = 1'b0; imem_ack_i = 1'b0;
        step();
        checks++; if (if_id_valid_o !== 1'b0 || if_id_instr_o !== 32'h13) begin errors++; $display("FAIL flush_stall_dropped got v=%b i=%h exp 0/00000013", if_id_valid_o, if_id_instr_o); end
        imem_ack_i = 1'b1;
        step();
        checks++; if (if_id_valid_o !== 1'b1 || if_id_pc_o !== 32'h0040_0200) begin errors++; $display("FAIL flush_stall_target got v=%b pc=%h exp 1/00400200", if_id_valid_o, if_id_pc_o); end
    endtask

    task automatic test_reset_mid_wait();
        flush_i = 1'b1; imem_ack_i = 1'b0; branch_target_i = 32'hFFFF_FFFC;
        step();
        flush_i = 1'b0;
        step();
        checks++; if (imem_addr_o !== 32'hFFFF_FFFC) begin errors++; $display("FAIL midwait_addr got %h exp fffffffc", imem_addr_o); end
        rst_i = 1'b1;
        step();
        checks++; if (imem_addr_o !== 32'h0040_0000 || if_id_valid_o !== 1'b0 || if_id_pc_o !== 32'h0) begin errors++; $display("FAIL midwait_reset got a=%h v=%b pc=%h exp 00400000/0/0", imem_addr_o, if_id_valid_o, if_id_pc_o); end
        rst_i = 1'b0;
    endtask

    task automatic test_wrap();
        flush_i = 1'b1; imem_ack_i = 1'b0; branch_target_i = 32'hFFFF_FFFE;
        step();
        flush_i = 1'b0; imem_ack_i = 1'b1;
        step();
        checks++; if (if_id_pc_o !== 32'hFFFF_FFFC || if_id_pc4_o !== 32'h0 || if_id_instr_o !== 32'h3) begin errors++; $display("FAIL wrap_last got pc=%h pc4=%h i=%h exp fffffffc/0/3", if_id_pc_o, if_id_pc4_o, if_id_instr_o); end
        checks++; if (imem_addr_o !== 32'h0) begin errors++; $display("FAIL wrap_addr got %h exp 0", imem_addr_o); end
        step();
        checks++; if (if_id_valid_o !== 1'b1 || if_id_pc_o !== 32'h0 || if_id_instr_o !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_zero got v=%b pc=%h i=%h exp 1/0/ffffffff", if_id_valid_o, if_id_pc_o, if_id_instr_o); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_wait();
        test_stall();
        test_flush_hold();
        test_flush_stall();
        test_reset_mid_wait();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
